mc_control_fsm: RTL and testbench

- Main sequencing FSM for the multicycle RV32I core.
- Decodes opcode per instruction and steps the shared datapath (one memory port, one ALU) through fetch, decode, execute, memory and writeback.
- Drives mux selects, write enables and the 2-bit ALUOp consumed by the ALU decoder.
- Stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/mc_control_if.sv | 32 +++
 rtl/mc_control_fsm.sv | 145 ++++++++++++++
 tb/tb_mc_control_fsm.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Control bundle between the multicycle sequencer and the shared RV32I datapath.
// The master modport belongs to the sequencer; the slave modport belongs to the datapath side.
interface mc_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic             BrTaken;
    logic             MemReady;
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemWrite;
    logic             IRWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             RegWrite;
    logic [1:0]       ALUOp;
    logic             Illegal;
    logic [CNT_W-1:0] Retired;

    modport master (
        input  op, BrTaken, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ALUOp, Illegal, Retired
    );

    modport slave (
        output op, BrTaken, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ALUOp, Illegal, Retired
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Main sequencing FSM of the multicycle RV32I core: steps the shared memory port and ALU
// through fetch/decode/execute/memory/writeback and counts retired instructions.
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.master bus
);

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_MEMADR   = 5'd2,
        S_MEMREAD  = 5'd3,
        S_MEMWB    = 5'd4,
        S_MEMWRITE = 5'd5,
        S_EXECR    = 5'd6,
        S_EXECI    = 5'd7,
        S_ALUWB    = 5'd8,
        S_BRANCH   = 5'd9,
        S_JAL      = 5'd10,
        S_JALR     = 5'd11,
        S_JALRLINK = 5'd12,
        S_LUI      = 5'd13,
        S_AUIPC    = 5'd14,
        S_TRAP     = 5'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // Moore part of the control word for a given state.
    function automatic ctrl_t moore_ctrl(state_t s);
        ctrl_t c;
        // NOTE: every field gets a default before the case, so no path leaves a value undriven.
        c = '0;
        case (s)
            S_FETCH:    begin c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            S_ALUWB:    c.reg_write = 1'b1;
            S_BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; end
            S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
            S_JALR: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pc_write   = 1'b1;
            end
            S_JALRLINK: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
            S_LUI:      begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
            S_AUIPC:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            S_TRAP:     c.illegal = 1'b1;
            default:    ;
        endcase
        return c;
    endfunction

    function automatic state_t next_state(state_t s, logic [6:0] op, logic mem_ready);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:    n = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: n = S_MEMADR;
                    7'b0110011:             n = S_EXECR;
                    7'b0010011:             n = S_EXECI;
                    7'b1100011:             n = S_BRANCH;
                    7'b1101111:             n = S_JAL;
                    7'b1100111:             n = S_JALR;
                    7'b0110111:             n = S_LUI;
                    7'b0010111:             n = S_AUIPC;
                    default:                n = S_TRAP;
                endcase
            end
            S_MEMADR:   n = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  n = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: n = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL, S_JALRLINK, S_LUI, S_AUIPC: n = S_ALUWB;
            S_JALR:     n = S_JALRLINK;
            S_TRAP:     n = S_TRAP;
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    state_t           state;
    state_t           state_nxt;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    always_comb begin
        state_nxt = next_state(state, bus.op, bus.MemReady);
        retire    = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                    ((state == S_MEMWRITE) && bus.MemReady);
    end

    // Control word is registered from the next state so it moves in lockstep with state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= S_FETCH;
            ctrl_q    <= moore_ctrl(S_FETCH);
            retired_q <= '0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= moore_ctrl(state_nxt);
            if (retire)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Handshake-dependent enables, all suppressed while reset is held.
    assign bus.PCWrite   = ~reset & (ctrl_q.pc_write |
                                     ((state == S_FETCH)  & bus.MemReady) |
                                     ((state == S_BRANCH) & bus.BrTaken));
    assign bus.IRWrite   = ~reset & (state == S_FETCH) & bus.MemReady;
    assign bus.MemWrite  = ~reset & ctrl_q.mem_write;
    assign bus.RegWrite  = ~reset & ctrl_q.reg_write;
    assign bus.AdrSrc    = ctrl_q.adr_src;
    assign bus.ResultSrc = ctrl_q.result_src;
    assign bus.ALUSrcA   = ctrl_q.alu_src_a;
    assign bus.ALUSrcB   = ctrl_q.alu_src_b;
    assign bus.ALUOp     = ctrl_q.alu_op;
    assign bus.Illegal   = ctrl_q.illegal;
    assign bus.Retired   = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a state-level reference model queues the expected
// control word and retire count each cycle; the DUT outputs are popped and compared mid-cycle.
module tb_mc_control_fsm;

    localparam int CNT_W = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_control_if #(.CNT_W(CNT_W)) bus ();
    mc_control_fsm #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef enum int {
        M_FETCH, M_DECODE, M_MEMADR, M_MEMREAD, M_MEMWB, M_MEMWRITE, M_EXECR, M_EXECI,
        M_ALUWB, M_BRANCH, M_JAL, M_JALR, M_JALRLINK, M_LUI, M_AUIPC, M_TRAP
    } mstate_t;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ALUOp, Illegal}
    typedef logic [13:0] ctrl_vec_t;
    typedef struct {
        string            tag;
        ctrl_vec_t        ctrl;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t             sb[$];
    mstate_t          ms;
    logic [CNT_W-1:0] mret;
    int               n_vec = 0;
    int               n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic ctrl_vec_t mk(logic pc, logic adr, logic mw, logic ir, logic [1:0] rs,
                                     logic [1:0] a, logic [1:0] b, logic rw, logic [1:0] aop,
                                     logic ill);
        return {pc, adr, mw, ir, rs, a, b, rw, aop, ill};
    endfunction

    function automatic ctrl_vec_t exp_ctrl(mstate_t s, logic mr, logic br, logic rst);
        ctrl_vec_t v;
        case (s)
            M_FETCH:    v = mk(mr,   1'b0, 1'b0, mr,   2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0);
            M_DECODE:   v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0);
            M_MEMADR:   v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0);
            M_MEMREAD:  v = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
            M_MEMWB:    v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
            M_MEMWRITE: v = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
            M_EXECR:    v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0);
            M_EXECI:    v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b10, 1'b0);
            M_ALUWB:    v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
            M_BRANCH:   v = mk(br,   1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b01, 1'b0);
            M_JAL:      v = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 2'b00, 1'b0);
            M_JALR:     v = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0);
            M_JALRLINK: v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 2'b00, 1'b0);
            M_LUI:      v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 1'b0, 2'b00, 1'b0);
            M_AUIPC:    v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0);
            default:    v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1);
        endcase
        if (rst)
            v = v & ~14'b10110000001000;
        return v;
    endfunction

    function automatic mstate_t mnext(mstate_t s, logic [6:0] op, logic mr);
        case (s)
            M_FETCH:    return mr ? M_DECODE : M_FETCH;
            M_DECODE: begin
                if (op == OP_LOAD || op == OP_STORE) return M_MEMADR;
                if (op == OP_R)     return M_EXECR;
                if (op == OP_I)     return M_EXECI;
                if (op == OP_BR)    return M_BRANCH;
                if (op == OP_JAL)   return M_JAL;
                if (op == OP_JALR)  return M_JALR;
                if (op == OP_LUI)   return M_LUI;
                if (op == OP_AUIPC) return M_AUIPC;
                return M_TRAP;
            end
            M_MEMADR:   return (op == OP_STORE) ? M_MEMWRITE : M_MEMREAD;
            M_MEMREAD:  return mr ? M_MEMWB : M_MEMREAD;
            M_MEMWRITE: return mr ? M_FETCH : M_MEMWRITE;
            M_JALR:     return M_JALRLINK;
            M_TRAP:     return M_TRAP;
            M_MEMWB, M_ALUWB, M_BRANCH: return M_FETCH;
            default:    return M_ALUWB;
        endcase
    endfunction

    // One clock cycle: drive, queue the expectation, compare mid-cycle, advance the model.
    task automatic step(input logic [6:0] op, input logic mr, input logic br, input logic rst);
        exp_t e;
        bus.op       = op;
        bus.MemReady = mr;
        bus.BrTaken  = br;
        reset        = rst;
        sb.push_back('{ms.name(), exp_ctrl(ms, mr, br, rst), mret});
        @(negedge clk);
        e = sb.pop_front();
        check({"ctrl@", e.tag}, 32'({bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                                     bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite,
                                     bus.ALUOp, bus.Illegal}), 32'(e.ctrl));
        check({"retired@", e.tag}, 32'(bus.Retired), 32'(e.ret));
        if (rst) begin
            ms   = M_FETCH;
            mret = '0;
        end else begin
            if (ms == M_MEMWB || ms == M_ALUWB || ms == M_BRANCH || (ms == M_MEMWRITE && mr))
                mret = mret + CNT_W'(1);
            ms = mnext(ms, op, mr);
        end
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; latency is taken from the DUT returning to its FETCH word.
    task automatic run_instr(input string name, input logic [6:0] op, input logic br,
                             input int stalls, input int exp_len);
        int  left;
        int  cycles;
        logic mr;
        left   = stalls;
        cycles = 0;
        for (int k = 0; k < 40; k++) begin
            mr = 1'b1;
            if ((ms == M_MEMREAD || ms == M_MEMWRITE) && left > 0) begin
                mr = 1'b0;
                left--;
            end
            step(op, mr, br, 1'b0);
            cycles = k + 1;
            if (bus.ResultSrc == 2'b10 && bus.ALUSrcB == 2'b10 && bus.Illegal == 1'b0)
                break;
        end
        check({"latency_", name}, 32'(cycles), 32'(exp_len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.op       = '0;
        bus.MemReady = 1'b0;
        bus.BrTaken  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ms   = M_FETCH;
        mret = '0;

        // Reset still held: FETCH with MemReady=1 must not enable PC/IR.
        step(OP_R, 1'b1, 1'b0, 1'b1);

        run_instr("add", OP_R, 1'b0, 0, 4);
        check("retired_after_add", 32'(bus.Retired), 32'd1);

        run_instr("load_stall", OP_LOAD, 1'b0, 3, 8);

        // Store stalled twice, reset lands in the second MEMWRITE cycle.
        step(OP_STORE, 1'b1, 1'b0, 1'b0);
        step(OP_STORE, 1'b1, 1'b0, 1'b0);
        step(OP_STORE, 1'b1, 1'b0, 1'b0);
        step(OP_STORE, 1'b0, 1'b0, 1'b0);
        step(OP_STORE, 1'b0, 1'b0, 1'b1);
        step(OP_R, 1'b0, 1'b0, 1'b0);
        check("retired_after_abort", 32'(bus.Retired), 32'd0);

        run_instr("br_nt", OP_BR, 1'b0, 0, 3);
        run_instr("br_t", OP_BR, 1'b1, 0, 3);
        check("retired_after_branches", 32'(bus.Retired), 32'd2);

        run_instr("jalr", OP_JALR, 1'b0, 0, 5);
        run_instr("jal", OP_JAL, 1'b0, 0, 4);
        run_instr("itype", OP_I, 1'b0, 0, 4);
        run_instr("lui", OP_LUI, 1'b0, 0, 4);
        run_instr("auipc", OP_AUIPC, 1'b0, 0, 4);
        run_instr("load", OP_LOAD, 1'b0, 0, 5);
        run_instr("store", OP_STORE, 1'b0, 0, 4);
        run_instr("store_stall", OP_STORE, 1'b0, 2, 6);

        // Unsupported opcode: trap and hold regardless of handshake inputs.
        step(7'b0000000, 1'b1, 1'b0, 1'b0);
        step(7'b0000000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        step(OP_R, 1'b1, 1'b1, 1'b1);
        step(OP_R, 1'b0, 1'b0, 1'b0);
        check("illegal_cleared", 32'(bus.Illegal), 32'd0);

        // Counter wrap: 15 retirements, then one more rolls the 4-bit count to zero.
        for (int i = 0; i < 15; i++)
            run_instr($sformatf("wrap%0d", i), OP_R, 1'b0, 0, 4);
        check("retired_at_15", 32'(bus.Retired), 32'd15);
        run_instr("wrap_last", OP_R, 1'b0, 0, 4);
        step(OP_R, 1'b0, 1'b0, 1'b0);
        check("retired_wrapped", 32'(bus.Retired), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
